// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell; the only combinational adder logic used by the
// serial add/subtract controller.
module Full_Adder (
  input  logic Ain,
  input  logic Bin,
  input  logic Cin,
  output logic S,
  output logic C
);

  logic w_p;

  assign w_p = Ain ^ Bin;
  assign S   = w_p ^ Cin;
  assign C   = (Ain & Bin) | (Cin & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: walks one Full_Adder cell across a
// WIDTH-bit operand pair, LSB first, one bit per clock.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_e           o_dbg_state
);

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); the edge
  // that samples it latches sub/a_in/b_in. done pulses for one cycle when
  // sum/cout/ovf are updated, and those outputs hold until the next done.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CMSB_IDX = CW'(WIDTH - 2);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_carry;
  logic             r_cmsb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic             w_accept;

  Full_Adder u_fa (
    .Ain (r_a_sr[0]),
    .Bin (r_b_sr[0]),
    .Cin (r_carry),
    .S   (w_s),
    .C   (w_c)
  );

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_cmsb   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            r_state  <= ST_ADD;
            r_a_sr   <= a_in;
            r_b_sr   <= sub ? ~b_in : b_in;
            r_carry  <= sub;
            r_cnt    <= '0;
            r_res_sr <= '0;
            r_busy   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ADD: begin
          r_res_sr <= {w_s, r_res_sr[WIDTH-1:1]};
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_carry  <= w_c;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CMSB_IDX) begin
            r_cmsb <= w_c;
          end
          if (r_cnt == LAST_IDX) begin
            // Signed overflow: carry into MSB differs from carry out of MSB.
            r_state <= ST_DONE;
            r_sum   <= {w_s, r_res_sr[WIDTH-1:1]};
            r_cout  <= w_c;
            r_ovf   <= w_c ^ r_cmsb;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed-vector bench for serial_adder_ctrl at WIDTH=4 with hand-computed
// sum/cout/ovf expectations, latency, busy, back-to-back and reset checks.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  state_e       dbg_state;

  int n_vec;
  int n_err;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sub         (sub),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Drive operands and start; returns #1 after the accept edge with start low.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded); done must appear WIDTH edges after the accept edge.
  task automatic finish_op(input string tag, input int elapsed,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    lat = 99;
    for (int k = elapsed + 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_busy_in_done"}, busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vecs[9];
  int   seen_done;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a_in  = '0;
    b_in  = '0;

    vecs[0] = '{4'd3,  4'd5, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[1] = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
    vecs[2] = '{4'd5,  4'd3, 1'b1, 4'd2,  1'b1, 1'b0};
    vecs[3] = '{4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    vecs[4] = '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[5] = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
    vecs[6] = '{4'd0,  4'd0, 1'b1, 4'd0,  1'b1, 1'b0};
    vecs[7] = '{4'd9,  4'd9, 1'b0, 4'd2,  1'b1, 1'b1};
    vecs[8] = '{4'd6,  4'd6, 1'b1, 4'd0,  1'b1, 1'b0};

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed arithmetic vectors
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      chk($sformatf("v%0d_busy", i), busy, 1);
      finish_op($sformatf("v%0d", i), 0, vecs[i].es, vecs[i].ec, vecs[i].eo);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_idle", i), dbg_state, ST_IDLE);
    end

    // start while busy is ignored: 5+3 must still return 8
    start_op(4'd5, 4'd3, 1'b0);
    @(posedge clk);
    #1;
    a_in  = 4'd7;
    b_in  = 4'd7;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ign_busy", busy, 1);
    finish_op("busy_ign", 2, 4'd8, 1'b0, 1'b1);

    // start held through DONE: next op accepted with no IDLE cycle
    @(posedge clk);
    #1;
    a_in  = 4'd2;
    b_in  = 4'd3;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a_in = 4'd1;
    b_in = 4'd1;
    finish_op("b2b1", 0, 4'd5, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_state", dbg_state, ST_ADD);
    chk("b2b_done_low", done, 0);
    finish_op("b2b2", 0, 4'd2, 1'b0, 1'b0);

    // reset asserted right after the 2nd ADD edge
    start_op(4'd3, 4'd5, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    chk("mid_rst_no_done", seen_done, 0);
    start_op(4'd6, 4'd7, 1'b0);
    finish_op("post_rst", 0, 4'd13, 1'b0, 1'b1);

    // start on the first edge after reset release is accepted
    rst = 1'b1;
    #1;
    rst = 1'b0;
    start_op(4'd4, 4'd9, 1'b1);
    finish_op("first_edge", 0, 4'd11, 1'b0, 1'b1);

    // outputs hold while inputs toggle with start low
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      a_in = 4'($urandom_range(0, 15));
      b_in = 4'($urandom_range(0, 15));
      sub  = 1'($urandom_range(0, 1));
      chk($sformatf("hold%0d_sum", k), sum, 4'd11);
      chk($sformatf("hold%0d_cout", k), cout, 0);
      chk($sformatf("hold%0d_ovf", k), ovf, 1);
      chk($sformatf("hold%0d_busy", k), busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
